// File: rtl/ts_link_monitor.sv
// Multi-channel link monitor: K28.5 transmit pattern, comma word alignment,
// per-channel lock FSM and saturating error/relock counters for slow control.

module ts_link_chan #(
   parameter int LOCK_COUNT = 16,
   parameter int ERR_LIMIT  = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk_125,
   input  logic             reset_soft,
   input  logic [15:0]      rx_d,
   input  logic [1:0]       rx_k,
   input  logic             rx_err,
   input  logic             rx_valid,
   input  logic             clear_counts,
   output logic [15:0]      aligned_d,
   output logic [1:0]       aligned_k,
   output logic             aligned_valid,
   output logic             locked,
   output logic             seq_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] relock_count
);

   localparam logic [7:0] COMMA  = 8'hBC;
   localparam logic [7:0] LOCK_N = 8'(LOCK_COUNT);
   localparam logic [7:0] ERR_N  = 8'(ERR_LIMIT);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t      state;
   logic        phase;
   logic [7:0]  good_cnt;
   logic [7:0]  bad_cnt;
   logic [7:0]  seq_last;
   logic        seq_seeded;
   logic [15:0] prev_d;
   logic [1:0]  prev_k;

   logic        comma0, comma1, al_comma, bad, seq_mis, lock_hit, drop, err_inc;
   logic [15:0] al_d;
   logic [1:0]  al_k;

   always_comb begin
      comma0   = (rx_k == 2'b01) && (rx_d[7:0] == COMMA);
      comma1   = (rx_k == 2'b10) && (rx_d[15:8] == COMMA);
      // phase 1 stitches the previous high byte under the current low byte
      al_d     = phase ? {rx_d[7:0], prev_d[15:8]} : prev_d;
      al_k     = phase ? {rx_k[0], prev_k[1]} : prev_k;
      al_comma = (al_k == 2'b01) && (al_d[7:0] == COMMA);
      bad      = rx_err | (phase ? (rx_k[0] && rx_d[7:0] == COMMA)
                                 : (rx_k[1] && rx_d[15:8] == COMMA));
      seq_mis  = (state == LOCKED) && al_comma && seq_seeded &&
                 (al_d[15:8] != seq_last + 8'd1);
      lock_hit = (state == VERIFY) && al_comma && !rx_err && (good_cnt + 8'd1 == LOCK_N);
      drop     = (state == LOCKED) && bad && (bad_cnt + 8'd1 == ERR_N);
      err_inc  = (state == LOCKED) && (bad || seq_mis);
   end

   always_ff @(posedge clk_125 or posedge reset_soft) begin
      if (reset_soft) begin
         state         <= HUNT;
         phase         <= 1'b0;
         good_cnt      <= '0;
         bad_cnt       <= '0;
         seq_last      <= '0;
         seq_seeded    <= 1'b0;
         prev_d        <= '0;
         prev_k        <= '0;
         aligned_d     <= '0;
         aligned_k     <= '0;
         aligned_valid <= 1'b0;
         locked        <= 1'b0;
         seq_err       <= 1'b0;
         err_count     <= '0;
         relock_count  <= '0;
      end else begin
         aligned_valid <= 1'b0;
         seq_err       <= 1'b0;
         if (rx_valid) begin
            prev_d    <= rx_d;
            prev_k    <= rx_k;
            aligned_d <= al_d;
            aligned_k <= al_k;
            seq_err   <= seq_mis;
            case (state)
               HUNT: begin
                  if (comma0 || comma1) begin
                     state    <= VERIFY;
                     phase    <= comma1;
                     good_cnt <= 8'd1;
                  end
               end
               VERIFY: begin
                  if (lock_hit) begin
                     state         <= LOCKED;
                     locked        <= 1'b1;
                     aligned_valid <= 1'b1;
                     good_cnt      <= '0;
                     bad_cnt       <= '0;
                     seq_seeded    <= 1'b0;
                  end else if (al_comma && !rx_err) begin
                     good_cnt <= good_cnt + 8'd1;
                  end else begin
                     state    <= HUNT;
                     good_cnt <= '0;
                  end
               end
               LOCKED: begin
                  // every comma re-seeds, so a mismatch resynchronises on the received value
                  if (al_comma) begin
                     seq_seeded <= 1'b1;
                     seq_last   <= al_d[15:8];
                  end
                  if (drop) begin
                     state   <= HUNT;
                     locked  <= 1'b0;
                     bad_cnt <= '0;
                  end else begin
                     aligned_valid <= 1'b1;
                     bad_cnt       <= bad ? bad_cnt + 8'd1 : 8'd0;
                  end
               end
               default: state <= HUNT;
            endcase
         end
         if (clear_counts) begin
            err_count    <= '0;
            relock_count <= '0;
         end else begin
            if (rx_valid && err_inc && (err_count != '1))
               err_count <= err_count + 1'b1;
            if (rx_valid && drop && (relock_count != '1))
               relock_count <= relock_count + 1'b1;
         end
      end
   end

endmodule

module ts_link_monitor #(
   parameter int NCH        = 2,
   parameter int LOCK_COUNT = 16,
   parameter int ERR_LIMIT  = 4,
   parameter int CNT_W      = 16
) (
   input  logic                 clk_125,
   input  logic                 reset_soft,
   input  logic [16*NCH-1:0]    rx_d,
   input  logic [2*NCH-1:0]     rx_k,
   input  logic [NCH-1:0]       rx_err,
   input  logic [NCH-1:0]       rx_valid,
   input  logic                 clear_counts,
   output logic [16*NCH-1:0]    tx_d,
   output logic [2*NCH-1:0]     tx_k,
   output logic [16*NCH-1:0]    aligned_d,
   output logic [2*NCH-1:0]     aligned_k,
   output logic [NCH-1:0]       aligned_valid,
   output logic [NCH-1:0]       locked,
   output logic [NCH-1:0]       seq_err,
   output logic [CNT_W*NCH-1:0] err_count,
   output logic [CNT_W*NCH-1:0] relock_count
);

   logic [7:0] seq;

   always_ff @(posedge clk_125 or posedge reset_soft) begin
      if (reset_soft) begin
         seq  <= '0;
         tx_d <= {NCH{16'h00BC}};
         tx_k <= {NCH{2'b01}};
      end else begin
         seq  <= seq + 8'd1;
         tx_d <= {NCH{{seq, 8'hBC}}};
         tx_k <= {NCH{2'b01}};
      end
   end

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      ts_link_chan #(
         .LOCK_COUNT(LOCK_COUNT),
         .ERR_LIMIT (ERR_LIMIT),
         .CNT_W     (CNT_W)
      ) u_ch (
         .clk_125      (clk_125),
         .reset_soft   (reset_soft),
         .rx_d         (rx_d[16*n +: 16]),
         .rx_k         (rx_k[2*n +: 2]),
         .rx_err       (rx_err[n]),
         .rx_valid     (rx_valid[n]),
         .clear_counts (clear_counts),
         .aligned_d    (aligned_d[16*n +: 16]),
         .aligned_k    (aligned_k[2*n +: 2]),
         .aligned_valid(aligned_valid[n]),
         .locked       (locked[n]),
         .seq_err      (seq_err[n]),
         .err_count    (err_count[CNT_W*n +: CNT_W]),
         .relock_count (relock_count[CNT_W*n +: CNT_W])
      );
   end

endmodule

// File: tb/tb_ts_link_monitor.sv
// Bench for ts_link_monitor: directed lock/error/sequence scenarios, a vector
// table on channel 0 and a randomized run against a byte-stream reference model.

module tb_ts_link_monitor;

   localparam int NCH        = 2;
   localparam int LOCK_COUNT = 16;
   localparam int ERR_LIMIT  = 4;
   localparam int CNT_W      = 4;
   localparam int CMAX       = (1 << CNT_W) - 1;

   logic                 clk_125 = 1'b0;
   logic                 reset_soft = 1'b0;
   logic [16*NCH-1:0]    rx_d = '0;
   logic [2*NCH-1:0]     rx_k = '0;
   logic [NCH-1:0]       rx_err = '0;
   logic [NCH-1:0]       rx_valid = '0;
   logic                 clear_counts = 1'b0;
   logic [16*NCH-1:0]    tx_d, aligned_d;
   logic [2*NCH-1:0]     tx_k, aligned_k;
   logic [NCH-1:0]       aligned_valid, locked, seq_err;
   logic [CNT_W*NCH-1:0] err_count, relock_count;

   ts_link_monitor #(.NCH(NCH), .LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(CNT_W)) dut (
      .clk_125(clk_125), .reset_soft(reset_soft), .rx_d(rx_d), .rx_k(rx_k), .rx_err(rx_err),
      .rx_valid(rx_valid), .clear_counts(clear_counts), .tx_d(tx_d), .tx_k(tx_k),
      .aligned_d(aligned_d), .aligned_k(aligned_k), .aligned_valid(aligned_valid),
      .locked(locked), .seq_err(seq_err), .err_count(err_count), .relock_count(relock_count)
   );

   always #4 clk_125 = ~clk_125;

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // reference model: works on the received byte stream per channel
   int          m_st [NCH];   // 0 hunting, 1 verifying, 2 locked
   int          m_ph [NCH];
   int          m_good [NCH], m_bad [NCH];
   int          m_seeded [NCH], m_last [NCH];
   int          m_err [NCH], m_rel [NCH];
   logic [15:0] m_pw [NCH];
   logic [1:0]  m_pk [NCH];
   int          e_lock [NCH], e_av [NCH], e_serr [NCH];
   logic [15:0] e_ad [NCH];
   logic [1:0]  e_ak [NCH];
   int          e_txhi, tx_cnt;

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_st[c] = 0; m_ph[c] = 0; m_good[c] = 0; m_bad[c] = 0;
         m_seeded[c] = 0; m_last[c] = 0; m_err[c] = 0; m_rel[c] = 0;
         m_pw[c] = '0; m_pk[c] = '0;
         e_lock[c] = 0; e_av[c] = 0; e_serr[c] = 0; e_ad[c] = '0; e_ak[c] = '0;
      end
      e_txhi = 0;
      tx_cnt = 0;
   endtask

   task automatic model_edge();
      logic [15:0] w, ad;
      logic [1:0]  k, ak;
      logic        e, acomma, isbad;
      int          inc_err, inc_rel;
      if (reset_soft) begin
         model_reset();
         return;
      end
      e_txhi = tx_cnt % 256;
      tx_cnt++;
      for (int c = 0; c < NCH; c++) begin
         e_serr[c] = 0;
         e_av[c]   = 0;
         if (rx_valid[c]) begin
            w = rx_d[16*c +: 16];
            k = rx_k[2*c +: 2];
            e = rx_err[c];
            if (m_ph[c] == 1) begin
               ad = {w[7:0], m_pw[c][15:8]};
               ak = {k[0], m_pk[c][1]};
            end else begin
               ad = m_pw[c];
               ak = m_pk[c];
            end
            acomma  = (ak == 2'b01) && (ad[7:0] == 8'hBC);
            inc_err = 0;
            inc_rel = 0;
            if (m_st[c] == 0) begin
               if (k == 2'b01 && w[7:0] == 8'hBC) begin
                  m_st[c] = 1; m_ph[c] = 0; m_good[c] = 1;
               end else if (k == 2'b10 && w[15:8] == 8'hBC) begin
                  m_st[c] = 1; m_ph[c] = 1; m_good[c] = 1;
               end
            end else if (m_st[c] == 1) begin
               if (acomma && !e) begin
                  m_good[c]++;
                  if (m_good[c] == LOCK_COUNT) begin
                     m_st[c] = 2; m_seeded[c] = 0; m_bad[c] = 0;
                  end
               end else begin
                  m_st[c] = 0; m_good[c] = 0;
               end
            end else begin
               isbad = e || ((m_ph[c] == 1) ? (k[0] && w[7:0] == 8'hBC)
                                            : (k[1] && w[15:8] == 8'hBC));
               if (acomma) begin
                  if (m_seeded[c] != 0 && int'(ad[15:8]) != (m_last[c] + 1) % 256) e_serr[c] = 1;
                  m_seeded[c] = 1;
                  m_last[c]   = int'(ad[15:8]);
               end
               inc_err = (isbad || e_serr[c] != 0) ? 1 : 0;
               if (isbad) begin
                  m_bad[c]++;
                  if (m_bad[c] == ERR_LIMIT) begin
                     m_st[c] = 0; m_bad[c] = 0; inc_rel = 1;
                  end
               end else m_bad[c] = 0;
            end
            m_pw[c] = w;
            m_pk[c] = k;
            e_ad[c] = ad;
            e_ak[c] = ak;
            e_av[c] = (m_st[c] == 2) ? 1 : 0;
            if (inc_err != 0 && m_err[c] < CMAX) m_err[c]++;
            if (inc_rel != 0 && m_rel[c] < CMAX) m_rel[c]++;
         end
         if (clear_counts) begin
            m_err[c] = 0;
            m_rel[c] = 0;
         end
         e_lock[c] = (m_st[c] == 2) ? 1 : 0;
      end
   endtask

   task automatic check_all();
      for (int c = 0; c < NCH; c++) begin
         check($sformatf("tx_d[%0d]", c), 32'(tx_d[16*c +: 16]), {16'h0, 8'(e_txhi), 8'hBC});
         check($sformatf("tx_k[%0d]", c), 32'(tx_k[2*c +: 2]), 32'd1);
         check($sformatf("locked[%0d]", c), 32'(locked[c]), 32'(e_lock[c]));
         check($sformatf("aligned_valid[%0d]", c), 32'(aligned_valid[c]), 32'(e_av[c]));
         check($sformatf("seq_err[%0d]", c), 32'(seq_err[c]), 32'(e_serr[c]));
         check($sformatf("err_count[%0d]", c), 32'(err_count[CNT_W*c +: CNT_W]), 32'(m_err[c]));
         check($sformatf("relock_count[%0d]", c), 32'(relock_count[CNT_W*c +: CNT_W]), 32'(m_rel[c]));
         if (e_av[c] != 0) begin
            check($sformatf("aligned_d[%0d]", c), 32'(aligned_d[16*c +: 16]), 32'(e_ad[c]));
            check($sformatf("aligned_k[%0d]", c), 32'(aligned_k[2*c +: 2]), 32'(e_ak[c]));
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_125);
      #1;
      check_all();
   endtask

   // stimulus: per-channel sequence counter and comma phase of the fed stream
   int sq [NCH];
   int ph_sel [NCH];

   // kind: 0 invalid, 1 good, 2 rx_err, 3 sequence jump, 4 garbage
   task automatic set_word(input int c, input int kind);
      rx_valid[c] = (kind != 0);
      rx_err[c]   = (kind == 2);
      if (kind == 3) sq[c] += 1;
      if (kind == 0 || kind == 4) begin
         rx_d[16*c +: 16] = 16'($urandom);
         rx_k[2*c +: 2]   = 2'($urandom);
      end else if (ph_sel[c] == 0) begin
         rx_d[16*c +: 16] = {8'(sq[c]), 8'hBC};
         rx_k[2*c +: 2]   = 2'b01;
      end else begin
         rx_d[16*c +: 16] = {8'hBC, 8'(sq[c] - 1)};
         rx_k[2*c +: 2]   = 2'b10;
      end
      if (kind != 0) sq[c]++;
   endtask

   typedef struct {
      bit v, e, j, clr;
      bit lock, serr;
      int err, rel;
   } vec_t;
   vec_t tbl [14];

   int serr_seen, gaps, drops, r;

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3, 0};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 0};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4, 0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
      tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1};
      tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1};

      for (int c = 0; c < NCH; c++) begin
         sq[c] = 0;
         ph_sel[c] = c;   // channel 1 receives the byte-shifted stream
      end
      model_reset();
      #1 reset_soft = 1'b1;
      tick();
      tick();
      check("reset_tx_d", 32'(tx_d), 32'h00BC00BC);
      check("reset_locked", 32'(locked), 32'd0);
      reset_soft = 1'b0;

      // lock-up: both channels lock exactly after the 16th word
      for (int n = 1; n <= 20; n++) begin
         set_word(0, 1);
         set_word(1, 1);
         tick();
         check($sformatf("lock_rise_w%0d", n), 32'(locked), (n >= LOCK_COUNT) ? 32'd3 : 32'd0);
         if (n >= 2)
            check($sformatf("aligned_w%0d", n), 32'(aligned_d), {2{8'(n - 2), 8'hBC}});
      end
      serr_seen = 0;
      gaps = 0;
      for (int n = 0; n < 280; n++) begin
         set_word(0, 1);
         set_word(1, 1);
         tick();
         if (seq_err != 0) serr_seen++;
         if (aligned_valid != 2'b11) gaps++;
      end
      check("loop_no_seq_err", 32'(serr_seen), 32'd0);
      check("loop_no_gaps", 32'(gaps), 32'd0);

      // error bursts on channel 0: 3 errors, 1 good, 4 errors
      for (int n = 0; n < 8; n++) begin
         set_word(0, (n == 3) ? 1 : 2);
         set_word(1, 1);
         tick();
         check($sformatf("burst_locked_%0d", n), 32'(locked[0]), (n == 7) ? 32'd0 : 32'd1);
      end
      check("burst_err_count", 32'(err_count[CNT_W-1:0]), 32'd7);
      check("burst_relock", 32'(relock_count[CNT_W-1:0]), 32'd1);

      for (int n = 0; n < 20; n++) begin
         set_word(0, 1);
         set_word(1, 1);
         tick();
      end
      check("relocked", 32'(locked), 32'd3);

      // one skipped sequence value while locked
      serr_seen = 0;
      drops = 0;
      for (int n = 0; n < 5; n++) begin
         set_word(0, (n == 0) ? 3 : 1);
         set_word(1, 1);
         tick();
         if (seq_err[0]) serr_seen++;
         if (!locked[0]) drops++;
      end
      check("skip_pulses", 32'(serr_seen), 32'd1);
      check("skip_err_count", 32'(err_count[CNT_W-1:0]), 32'd8);
      check("skip_no_drop", 32'(drops), 32'd0);

      // vector table on channel 0, counters cleared first
      clear_counts = 1'b1;
      set_word(0, 1);
      set_word(1, 1);
      tick();
      clear_counts = 1'b0;
      for (int i = 0; i < 14; i++) begin
         set_word(0, !tbl[i].v ? 0 : tbl[i].j ? 3 : tbl[i].e ? 2 : 1);
         rx_err[0] = tbl[i].e;
         clear_counts = tbl[i].clr;
         set_word(1, 1);
         tick();
         clear_counts = 1'b0;
         check($sformatf("tbl%0d_locked", i), 32'(locked[0]), 32'(tbl[i].lock));
         check($sformatf("tbl%0d_seq_err", i), 32'(seq_err[0]), 32'(tbl[i].serr));
         check($sformatf("tbl%0d_err", i), 32'(err_count[CNT_W-1:0]), 32'(tbl[i].err));
         check($sformatf("tbl%0d_relock", i), 32'(relock_count[CNT_W-1:0]), 32'(tbl[i].rel));
      end

      // saturation on channel 1 via repeated sequence jumps
      for (int n = 0; n < 20; n++) begin
         set_word(0, 1);
         set_word(1, 3);
         tick();
      end
      check("sat_err_count", 32'(err_count[2*CNT_W-1:CNT_W]), 32'(CMAX));
      check("sat_locked", 32'(locked[1]), 32'd1);
      clear_counts = 1'b1;
      set_word(0, 1);
      set_word(1, 3);
      tick();
      clear_counts = 1'b0;
      check("clear_wins", 32'(err_count[2*CNT_W-1:CNT_W]), 32'd0);

      // asynchronous reset mid-operation
      reset_soft = 1'b1;
      #1;
      model_reset();
      check("async_locked", 32'(locked), 32'd0);
      check_all();
      tick();
      reset_soft = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 199) == 0) ph_sel[c] = 1 - ph_sel[c];
            r = $urandom_range(0, 99);
            set_word(c, (r < 8) ? 0 : (r < 13) ? 2 : (r < 16) ? 3 : (r < 19) ? 4 : 1);
         end
         clear_counts = ($urandom_range(0, 99) < 2);
         tick();
      end
      clear_counts = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ts_link_monitor.md
# ts_link_monitor

Parametrised multi-channel link monitor and word aligner for the trigger-scintillator serial links. It sits between the transceiver wrapper and the TS data path in the `clk_125` domain, and performs four jobs:
- generates the standard transmit pattern: a K28.5 comma plus an incrementing sequence byte;
- byte-aligns each received 16-bit stream on the comma;
- runs a per-channel lock state machine;
- keeps saturating error and relock counters for slow control.

Receive data arrives already resynchronised to `clk_125`.

## Interface
Parameters:
- `NCH`, default 2: number of link channels.
- `LOCK_COUNT`, default 16: consecutive good comma words required to declare lock (legal range 2..255).
- `ERR_LIMIT`, default 4: consecutive bad words that drop lock (legal range 1..255).
- `CNT_W`, default 16: width of each error and relock counter.

Ports:
- `clk_125`  in  1  sole clock.
- `reset_soft`  in  1  reset, asynchronous, active-high.
- `rx_d`  in  16*NCH  decoded receive data; channel n occupies [16n+15:16n].
- `rx_k`  in  2*NCH  K flags, one per byte.
- `rx_err`  in  NCH  disparity or not-in-table error for the word.
- `rx_valid`  in  NCH  qualifies `rx_d`, `rx_k` and `rx_err`.
- `clear_counts`  in  1  synchronous clear of all counters.
- `tx_d`  out  16*NCH  transmit word, {seq, 8'hBC}, identical on all channels.
- `tx_k`  out  2*NCH  2'b01 per channel.
- `aligned_d`  out  16*NCH  comma-aligned data; comma is in the low byte.
- `aligned_k`  out  2*NCH  K flags for `aligned_d`.
- `aligned_valid`  out  NCH  aligned word valid; asserted only while locked.
- `locked`  out  NCH  channel locked.
- `seq_err`  out  NCH  one-cycle pulse on a sequence-byte mismatch.
- `err_count`  out  CNT_W*NCH  saturating count of bad words.
- `relock_count`  out  CNT_W*NCH  saturating count of lock losses.

## Operation
- **TX pattern.** An 8-bit counter `seq` increments every `clk_125` cycle and wraps 255→0. Drive `tx_d = {seq, 8'hBC}` and `tx_k = 2'b01` on every channel, registered.
- **Comma word at phase p.** A word has a comma at phase p when all three hold:
  - `rx_k` bit p = 1;
  - byte p = 8'hBC;
  - the other K bit = 0.
- **Alignment.** Each channel keeps the previous valid word.
  - Phase 0: the aligned word is the previous valid word.
  - Phase 1: the aligned word is {current low byte, previous high byte}, with K bits arranged the same way.
- **rx_valid = 0.** The word is ignored entirely: no state, counter or previous-word update, and `aligned_valid` = 0.
- **FSM states (per channel).** HUNT, VERIFY, LOCKED. Reset enters HUNT.
  - HUNT → VERIFY on a valid comma word at either phase. Latch the phase; good_cnt = 1.
  - VERIFY → LOCKED on reaching good_cnt = LOCK_COUNT. Each aligned word that is a comma word at phase 0 with `rx_err` = 0 increments good_cnt.
  - VERIFY → HUNT on any other valid word. good_cnt is cleared.
  - LOCKED: a word is bad if `rx_err` = 1, or it carries 8'hBC with K set in the non-latched byte position. A good word clears bad_cnt.
  - LOCKED → HUNT on bad_cnt = ERR_LIMIT. `relock_count` increments.
- **Sequence check (LOCKED only).**
  - The first comma word after entering LOCKED seeds the expected value.
  - Each later comma word's high byte must equal the previous value + 1, mod 256.
  - On a mismatch, pulse `seq_err` and re-seed from the received value.
  - Non-comma words are not checked.
- **`err_count`.** Increments once per word that is bad or causes `seq_err`; a word that is both counts once. Saturates at all-ones.
- **`clear_counts`.** Zeroes all counters in the cycle it is sampled. It has priority over a simultaneous increment. It does not affect the FSM.

## Timing
- **Reset values.**
  - `tx_d` = {8'h00, 8'hBC} per channel; `tx_k` = 2'b01.
  - All other outputs 0, including `locked`, `aligned_valid`, `seq_err` and both counters.
  - `seq` starts at 0, so the first cycle after reset release outputs seq 0, then 1, and so on.
- **Reset mid-operation.** All channels return to HUNT immediately and asynchronously.
- **Latency.**
  - `aligned_*` is registered: valid one cycle after the input word that completes the aligned word.
  - Phase 0 = 2 cycles from the word's input; phase 1 = 1 cycle after its second half.
  - `locked` rises one cycle after the LOCK_COUNT-th good word is sampled.
  - `locked` falls, and `relock_count` increments, one cycle after the ERR_LIMIT-th consecutive bad word is sampled.
  - `seq_err` and the `err_count` update occur one cycle after the offending aligned word.
- **Simultaneous events.** A bad word that triggers relock counts in both `err_count` and `relock_count`. The word that drops lock does not produce `aligned_valid`.
- **Independence.** Channels are fully independent; one channel's state never affects another.

## Test plan
- Reset, then release: `tx_d` shows 16'h00BC, 16'h01BC, …; it wraps from 16'hFFBC to 16'h00BC.
- Loop `tx` back to `rx` on both channels, phase 0, `rx_valid` = 1:
  - `locked` rises exactly 1 cycle after word 16;
  - `aligned_d` reproduces `tx_d` 2 cycles later;
  - `seq_err` stays 0.
- Channel 1 fed byte-shifted, with the comma in the high byte: locks in phase 1, and `aligned_d` = {seq, 8'hBC} with no gaps.
- Inject `rx_err` on 3 consecutive words, then 1 good word, then 4 errors:
  - `locked` stays up through the first 3 errors;
  - it drops after the 4th error of the second burst;
  - `err_count` = 7 and `relock_count` = 1.
- Skip one sequence value while locked: a single `seq_err` pulse; `err_count` +1; `locked` remains 1.
- With `CNT_W` = 4, force 20 errors: `err_count` saturates at 15. Then assert `clear_counts` coincident with an error: `err_count` = 0.
